// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver with scancode FIFO and irq.
// Optional break-code folding: define PS2_BREAK_DECODE_EN.
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    output logic [8:0] rd_data,
    output logic       valid,
    output logic       irq,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          clk_s1;
    logic          clk_s2;
    logic          dat_s1;
    logic          dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          filt_chg;
    logic          fall;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_q;
    logic          par_ok;
    logic          push;
    logic          err;
    logic          push_en;
    logic [8:0]    wdata;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          do_push;
    logic          drop;

    // Two-stage synchronisers for both PS/2 lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // A new clock level must persist FILT_LEN samples to be accepted
    assign filt_chg = (clk_s2 != filt_clk)
                   && (filt_cnt == FW'(FILT_LEN - 1));
    assign fall     = filt_chg && filt_clk;

    // Glitch filter on the synchronised clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_chg) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // An edge in the same cycle wins over an expiring timeout
    assign to_hit = (state_q != IDLE)
                 && (to_cnt == TW'(TIMEOUT_CYC - 1))
                 && !filt_chg;

    // Inactivity counter for aborting partial frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state_q == IDLE || filt_chg || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign par_ok = ^{shreg, par_q};

    // FSM next state plus push/error decisions
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        err     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall && !dat_s2) state_d = DATA;
            end
            DATA: begin
                if (fall && bitcnt == 3'd7) state_d = PARITY;
            end
            PARITY: begin
                if (fall) state_d = STOP;
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (dat_s2 && par_ok) push = 1'b1;
                    else                  err  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (to_hit) begin
            state_d = IDLE;
            push    = 1'b0;
            err     = 1'b1;
        end
    end

    // Frame shift register, bit counter and parity latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt <= '0;
            shreg  <= '0;
            par_q  <= 1'b0;
        end else if (fall) begin
            unique case (state_q)
                IDLE: bitcnt <= '0;
                DATA: begin
                    shreg  <= {dat_s2, shreg[7:1]};
                    bitcnt <= bitcnt + 1'b1;
                end
                PARITY:  par_q <= dat_s2;
                default: ;
            endcase
        end
    end

    // Registered one-cycle error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_err <= 1'b0;
        else        frame_err <= err;
    end

`ifdef PS2_BREAK_DECODE_EN
    logic pend_q;
    logic is_brk;

    assign is_brk  = (shreg == 8'hF0);
    assign push_en = push && !is_brk;
    assign wdata   = {pend_q, shreg};

    // Remember an F0 prefix for the following byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pend_q <= 1'b0;
        else if (err)  pend_q <= 1'b0;
        else if (push) pend_q <= is_brk;
    end
`else
    assign push_en = push;
    assign wdata   = {1'b0, shreg};
`endif

    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign pop     = rd && !empty;
    assign do_push = push_en && (!full || pop);
    assign drop    = push_en && full && !pop;

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow, cleared by a read unless a drop coincides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
        else if (rd)   overflow <= 1'b0;
    end

    assign valid   = !empty;
    assign irq     = valid;
    assign rd_data = empty ? 9'h000 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed self-checking bench for ps2_keyboard_rx.
// Honours PS2_BREAK_DECODE_EN when defined.
module tb_ps2_keyboard_rx;

    localparam int HP   = 50;
    localparam int TOUT = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd = 1'b0;
    logic [8:0] rd_data;
    logic       valid;
    logic       irq;
    logic       overflow;
    logic       frame_err;

    int tests = 0;
    int fails = 0;
    int errs  = 0;
    int e0;

    ps2_keyboard_rx #(
        .FIFO_DEPTH (8),
        .FILT_LEN   (4),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rd       (rd),
        .rd_data  (rd_data),
        .valid    (valid),
        .irq      (irq),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && frame_err) errs++;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic flip,
                              input int nbits);
        logic [10:0] fb;
        fb = {1'b1, (~^d) ^ flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fb[i];
            cyc(HP);
            ps2_clk = 1'b0;
            cyc(HP);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(HP);
    endtask

    task automatic pop_one;
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
    endtask

    initial begin
        cyc(5);
        check("rst_valid", valid, 0);
        check("rst_irq", irq, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_data", rd_data, 0);
        rst_n = 1'b1;
        cyc(10);

        // single frame 0x1C with stop-bit latency window
        send_frame(8'h1C, 1'b0, 10);
        ps2_data = 1'b1;
        cyc(HP);
        ps2_clk = 1'b0;
        cyc(3);
        check("lat_early", valid, 0);
        cyc(5);
        check("lat_valid", valid, 1);
        check("lat_irq", irq, 1);
        check("f1c_data", rd_data, 9'h01C);
        cyc(HP);
        ps2_clk = 1'b1;
        cyc(HP);
        pop_one();
        check("f1c_pop", valid, 0);
        check("f1c_irq0", irq, 0);

        // parity error, then good 0x32
        e0 = errs;
        send_frame(8'h1C, 1'b1, 11);
        check("par_err", errs - e0, 1);
        check("par_valid", valid, 0);
        send_frame(8'h32, 1'b0, 11);
        check("f32_data", rd_data, 9'h032);
        check("f32_err", errs - e0, 1);
        pop_one();

        // timeout on a partial frame
        e0 = errs;
        send_frame(8'hA5, 1'b0, 5);
        cyc(TOUT + 10);
        check("to_err", errs - e0, 1);
        check("to_valid", valid, 0);
        send_frame(8'h21, 1'b0, 11);
        check("f21_data", rd_data, 9'h021);
        check("f21_valid", valid, 1);
        pop_one();

        // 2-cycle glitch while idle with data low
        e0 = errs;
        ps2_data = 1'b0;
        cyc(HP);
        ps2_clk = 1'b0;
        cyc(2);
        ps2_clk = 1'b1;
        cyc(HP);
        ps2_data = 1'b1;
        cyc(HP);
        check("gl_err", errs - e0, 0);
        check("gl_valid", valid, 0);
        send_frame(8'h55, 1'b0, 11);
        check("gl_next", rd_data, 9'h055);
        pop_one();

        // overflow with nine frames
        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), 1'b0, 11);
        check("ovf_set", overflow, 1);
        check("ovf_head", rd_data, 9'h001);
        pop_one();
        check("ovf_clr", overflow, 0);
        check("ovf_next", rd_data, 9'h002);
        for (int i = 2; i <= 8; i++) begin
            check("ovf_drain", rd_data, 9'(i));
            pop_one();
        end
        check("ovf_empty", valid, 0);

        // break-code handling
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h1C, 1'b0, 11);
`ifdef PS2_BREAK_DECODE_EN
        check("brk_data", rd_data, 9'h11C);
        pop_one();
        check("brk_one", valid, 0);
`else
        check("nobrk_f0", rd_data, 9'h0F0);
        pop_one();
        check("nobrk_1c", rd_data, 9'h01C);
        pop_one();
        check("nobrk_two", valid, 0);
`endif

        // reset mid-frame with data pending
        send_frame(8'h12, 1'b0, 11);
        check("mr_pend", valid, 1);
        send_frame(8'h44, 1'b0, 4);
        rst_n = 1'b0;
        cyc(3);
        check("mr_valid", valid, 0);
        check("mr_data", rd_data, 0);
        check("mr_ovf", overflow, 0);
        rst_n = 1'b1;
        cyc(10);
        send_frame(8'h33, 1'b0, 11);
        check("mr_next", rd_data, 9'h033);
        pop_one();
        check("mr_empty", valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
